// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, inst} FIFO between fetch and decode.
// Presents a NOP bubble to decode while empty; flush empties it in one cycle.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          inst_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          pc_o,
    output logic [XLEN-1:0]          inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [XLEN-1:0] r_inst [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign in_ready_o  = r_count != CW'(DEPTH);
    assign out_valid_o = r_count != '0;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;
    assign pc_o        = out_valid_o ? r_pc[r_rd_ptr] : '0;
    assign inst_o      = out_valid_o ? r_inst[r_rd_ptr] : NOP_INST;
    assign count_o     = r_count;

    // Pointers are DEPTH-sized (power of two), so increments wrap on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_pc[r_wr_ptr]   <= pc_i;
            r_inst[r_wr_ptr] <= inst_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue; a driver queues expected
// entries on accepted pushes, a negedge monitor compares DUT outputs against them.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 0;
    logic        rst_i = 1;
    logic        flush_i = 0;
    logic        in_valid_i = 0;
    logic        in_ready_o;
    logic [31:0] pc_i = 0;
    logic [31:0] inst_i = 0;
    logic        out_valid_o;
    logic        out_ready_i = 0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [2:0]  count_o;

    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          run = 0;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .inst_o(inst_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares outputs with the model mid-cycle, consumes an entry on handshake.
    always @(negedge clk_i) begin
        if (run && !rst_i) begin
            chk("count", count_o, exp_q.size());
            chk("in_ready", in_ready_o, exp_q.size() < DEPTH);
            chk("out_valid", out_valid_o, exp_q.size() != 0);
            if (exp_q.size() == 0) begin
                chk("pc_empty", pc_o, 0);
                chk("inst_empty", inst_o, NOP);
            end else begin
                chk("pc_head", pc_o, exp_q[0][63:32]);
                chk("inst_head", inst_o, exp_q[0][31:0]);
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; acceptance is decided from the model's occupancy.
    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                        input logic r, input logic f);
        logic acc;
        in_valid_i = v; pc_i = p; inst_i = ins; out_ready_i = r; flush_i = f;
        acc = v && (exp_q.size() < DEPTH);
        @(posedge clk_i); #1;
        if (f) exp_q.delete();
        else if (acc) exp_q.push_back({p, ins});
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_count", count_o, 0);
        chk("rst_ready", in_ready_o, 1);
        rst_i = 0;
        run = 1;

        // latency and order
        step(1, 32'h100, 32'hAAAA0001, 1, 0);
        step(1, 32'h104, 32'hAAAA0002, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("drained", count_o, 0);

        // fill and stall: fifth entry refused and held by fetch
        for (int i = 0; i < 5; i++) step(1, 32'h100 + 4 * i, 32'hBBBB0000 + i, 0, 0);
        chk("full_ready", in_ready_o, 0);
        chk("full_head", pc_o, 32'h100);
        // simultaneous push and pop at full: pop only
        step(1, 32'h110, 32'hBBBB0004, 1, 0);
        chk("after_full_count", count_o, 3);
        chk("after_full_ready", in_ready_o, 1);
        step(1, 32'h110, 32'hBBBB0004, 0, 0);
        chk("fifth_kept", count_o, 4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // wrap-around streaming
        for (int i = 0; i < 12; i++) step(1, 4 * i, 32'hCCCC0000 + i, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("stream_drained", count_o, 0);

        // flush with push and pop in the same cycle
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 4 * i, 32'hDDDD0000 + i, 0, 0);
        step(1, 32'h200, 32'hEEEE0000, 1, 1);
        chk("flush_count", count_o, 0);
        chk("flush_valid", out_valid_o, 0);
        chk("flush_inst", inst_o, NOP);
        chk("flush_ready", in_ready_o, 1);

        // asynchronous reset mid-cycle with 3 entries queued
        for (int i = 0; i < 3; i++) step(1, 32'h400 + 4 * i, 32'hFFFF0000 + i, 0, 0);
        in_valid_i = 0;
        #2 rst_i = 1;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_count", count_o, 0);
        chk("arst_inst", inst_o, NOP);
        chk("arst_pc", pc_o, 0);
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_i = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 0);
        chk("final_count", count_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between fetch and decode, succeeding the single-entry IF/ID register. It buffers up to DEPTH {pc, inst} pairs from fetch and presents the oldest entry to decode under a valid/ready handshake. Fetch can keep running while decode stalls, and a flush discards all buffered entries in one cycle. When the queue is empty, decode sees a NOP bubble.

## Interface
- XLEN, 32: width of pc and inst.
- DEPTH, 4: number of entries; power of two, at least 2.
- NOP_INST, 32'h0000_0013: instruction presented while the queue is empty (addi x0,x0,0).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous discard of every entry (branch or exception redirect).
- in_valid_i  input  1  fetch presents a valid pc_i/inst_i.
- in_ready_o  output  1  the queue accepts an entry this cycle.
- pc_i  input  XLEN  fetch PC.
- inst_i  input  XLEN  fetched instruction.
- out_valid_o  output  1  pc_o/inst_o hold a valid entry.
- out_ready_i  input  1  decode consumes the entry (the inverse of decode stall).
- pc_o  output  XLEN  PC of the head entry, or 0 when empty.
- inst_o  output  XLEN  instruction of the head entry, or NOP_INST when empty.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
**State**
- Storage array of DEPTH entries.
- wr_ptr and rd_ptr, each $clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0.
- count register.

**Handshakes**
- push = in_valid_i & in_ready_o.
- pop = out_valid_o & out_ready_i.

**Combinational outputs** (no combinational path from any input to any output)
- in_ready_o = (count != DEPTH). It does not depend on out_ready_i, so there is no pass-through when full.
- out_valid_o = (count != 0).
- pc_o and inst_o are read combinationally from the entry at rd_ptr when out_valid_o=1. Otherwise pc_o=0 and inst_o=NOP_INST.

**Per-cycle update, in priority order**
1. rst_i high (asynchronous): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care.
2. flush_i high: wr_ptr=0, rd_ptr=0, count=0. Any push or pop in the same cycle is ignored, and the pushed entry is discarded.
3. Otherwise:
   - On push: write {pc_i, inst_i} to storage at wr_ptr, then wr_ptr+1.
   - On pop: rd_ptr+1.
   - count becomes count + push - pop. Push and pop together leave count unchanged.

**Stall and order**
- No entry is ever dropped or duplicated outside a flush.
- While out_valid_o=1 and out_ready_i=0, pc_o and inst_o hold stable.
- Entries leave in FIFO order.

## Timing
**Reset values** (during and after rst_i, until the first push)
- out_valid_o=0, pc_o=0, inst_o=NOP_INST, count_o=0, in_ready_o=1.

**Latency**
- An entry pushed at edge N is visible on pc_o/inst_o with out_valid_o=1 immediately after edge N. This is one-cycle latency, matching the old IF/ID register.

**Throughput**
- One push and one pop per cycle sustained, at any count from 1 to DEPTH-1.

**Full queue** (count=DEPTH)
- in_ready_o=0 and any push is refused.
- A pop that cycle makes in_ready_o=1 in the next cycle.

**Empty queue** (count=0)
- out_ready_i is ignored.
- A push that cycle makes out_valid_o=1 in the next cycle.
- There is no same-cycle bypass.

**Flush**
- After the flush edge, the queue is empty (out_valid_o=0, inst_o=NOP_INST, count_o=0) and in_ready_o=1.

**Reset mid-operation**
- Asserting rst_i takes effect immediately, without waiting for a clock edge.
- Deasserting rst_i must be synchronous to clk_i; the surrounding reset synchroniser guarantees this.

## Test plan
- **Reset:** assert rst_i mid-cycle with 3 entries queued -> out_valid_o=0, count_o=0, inst_o=32'h0000_0013 and pc_o=0 before the next edge.
- **Latency and order:** push pc=0x100/inst=0xAAAA0001, then pc=0x104/inst=0xAAAA0002, with out_ready_i=1 -> each appears one cycle after its push, in order; count_o returns to 0.
- **Fill and stall:** with out_ready_i=0, push 5 entries at DEPTH=4 -> first 4 accepted; in_ready_o=0 after the 4th; the 5th is held by fetch and is not lost; head stays at the first entry (pc=0x100).
- **Simultaneous at full:** at count=4, in_valid_i=1 and out_ready_i=1 -> pop only that cycle (in_ready_o=0); next cycle count=3 and in_ready_o=1.
- **Wrap-around:** stream 12 entries with pc 0x0..0x2C at one push and one pop per cycle -> all 12 delivered in order; count_o stays 1 after the first push.
- **Flush:** with 3 entries queued, assert flush_i together with push pc=0x200 and pop -> next cycle count_o=0, out_valid_o=0, inst_o=NOP; pc 0x200 never appears at the output.
